// File: rtl/emu_host_sequencer_if.sv
// Host wire endpoints plus the emulator core io_host channels for emu_host_sequencer.
// The sequencer takes the slave modport; the host/core environment takes master.
interface emu_host_sequencer_if #(
    parameter int DATA_W  = 16,
    parameter int STEP_W  = 16,
    parameter int PROC_W  = 3,
    parameter int DEPTH_W = 8
);
    logic [STEP_W-1:0]         cfg_host_steps;
    logic [PROC_W-1:0]         cfg_used_procs;
    logic [DEPTH_W-1:0]        cfg_insns_per_proc;
    logic                      start_toggle;
    logic                      insn_toggle;
    logic [DATA_W-1:0]         insn_bits_0;
    logic [DATA_W-1:0]         insn_bits_1;
    logic                      in_toggle;
    logic [DATA_W-1:0]         in_bits;
    logic                      out_toggle;
    logic                      insn_ack;
    logic                      in_ack;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_bits;
    logic [1:0]                state;
    logic [PROC_W+DEPTH_W-1:0] insns_loaded;
    logic [STEP_W-1:0]         steps_done;
    logic                      err;
    logic                      core_insns_valid;
    logic                      core_insns_ready;
    logic [DATA_W-1:0]         core_insns_bits_0;
    logic [DATA_W-1:0]         core_insns_bits_1;
    logic                      core_io_i_valid;
    logic                      core_io_i_ready;
    logic [DATA_W-1:0]         core_io_i_bits;
    logic                      core_io_o_valid;
    logic                      core_io_o_ready;
    logic [DATA_W-1:0]         core_io_o_bits;

    modport slave (
        input  cfg_host_steps, cfg_used_procs, cfg_insns_per_proc,
        input  start_toggle, insn_toggle, insn_bits_0, insn_bits_1,
        input  in_toggle, in_bits, out_toggle,
        input  core_insns_ready, core_io_i_ready, core_io_o_valid, core_io_o_bits,
        output insn_ack, in_ack, out_valid, out_bits, state, insns_loaded, steps_done, err,
        output core_insns_valid, core_insns_bits_0, core_insns_bits_1,
        output core_io_i_valid, core_io_i_bits, core_io_o_ready
    );

    modport master (
        output cfg_host_steps, cfg_used_procs, cfg_insns_per_proc,
        output start_toggle, insn_toggle, insn_bits_0, insn_bits_1,
        output in_toggle, in_bits, out_toggle,
        output core_insns_ready, core_io_i_ready, core_io_o_valid, core_io_o_bits,
        input  insn_ack, in_ack, out_valid, out_bits, state, insns_loaded, steps_done, err,
        input  core_insns_valid, core_insns_bits_0, core_insns_bits_1,
        input  core_io_i_valid, core_io_i_bits, core_io_o_ready
    );
endinterface

// File: rtl/emu_host_sequencer.sv
// Turns host toggle bits into single valid/ready beats toward the emulator core and
// sequences a run.  state | meaning: IDLE | wait start; LOAD | forward insns; RUN | io traffic; DONE | run complete
module emu_host_sequencer #(
    parameter int DATA_W  = 16,
    parameter int STEP_W  = 16,
    parameter int PROC_W  = 3,
    parameter int DEPTH_W = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    emu_host_sequencer_if.slave  bus
);
    localparam int CNT_W = PROC_W + DEPTH_W;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

    state_t              r_state;
    logic                r_start_seen, r_insn_seen, r_in_seen, r_out_seen;
    logic                r_insn_valid, r_insn_ack, r_in_valid, r_in_ack;
    logic [DATA_W-1:0]   r_insn_bits_0, r_insn_bits_1, r_in_bits;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_bits;
    logic [CNT_W-1:0]    r_expected, r_insns_loaded;
    logic [STEP_W-1:0]   r_steps, r_steps_done;
    logic                r_err;

    logic w_start_pend, w_insn_pend, w_in_pend, w_out_pend;
    logic w_start_ok, w_insn_hs, w_in_hs, w_out_ready, w_out_hs, w_err_set;
    logic [CNT_W-1:0]  w_loaded_nxt;
    logic [STEP_W-1:0] w_steps_nxt;

    assign w_start_pend = bus.start_toggle != r_start_seen;
    assign w_insn_pend  = bus.insn_toggle  != r_insn_seen;
    assign w_in_pend    = bus.in_toggle    != r_in_seen;
    assign w_out_pend   = bus.out_toggle   != r_out_seen;
    assign w_start_ok   = w_start_pend && (r_state == S_IDLE || r_state == S_DONE);
    assign w_insn_hs    = r_insn_valid && bus.core_insns_ready;
    assign w_in_hs      = r_in_valid && bus.core_io_i_ready;
    // Stop accepting io_o once the target is met so steps_done cannot pass it.
    assign w_out_ready  = (r_state == S_RUN) && !r_out_valid && (r_steps_done != r_steps);
    assign w_out_hs     = w_out_ready && bus.core_io_o_valid;
    assign w_loaded_nxt = r_insns_loaded + CNT_W'(1);
    assign w_steps_nxt  = r_steps_done + STEP_W'(1);
    assign w_err_set    = (w_start_pend && !w_start_ok)
                        || (w_insn_pend && (r_insn_valid || r_state != S_LOAD))
                        || (w_in_pend && (r_in_valid || r_state != S_RUN))
                        || (w_out_pend && !r_out_valid);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_start_seen   <= 1'b0;
            r_insn_seen    <= 1'b0;
            r_in_seen      <= 1'b0;
            r_out_seen     <= 1'b0;
            r_insn_valid   <= 1'b0;
            r_insn_ack     <= 1'b0;
            r_in_valid     <= 1'b0;
            r_in_ack       <= 1'b0;
            r_insn_bits_0  <= '0;
            r_insn_bits_1  <= '0;
            r_in_bits      <= '0;
            r_out_valid    <= 1'b0;
            r_out_bits     <= '0;
            r_expected     <= '0;
            r_insns_loaded <= '0;
            r_steps        <= '0;
            r_steps_done   <= '0;
            r_err          <= 1'b0;
        end else begin
            r_err <= (w_start_ok ? 1'b0 : r_err) | w_err_set;
            if (w_start_pend)
                r_start_seen <= bus.start_toggle;

            // A flip arriving while busy stays pending and is taken after the beat.
            if (w_insn_hs) begin
                r_insn_valid <= 1'b0;
                r_insn_ack   <= ~r_insn_ack;
            end else if (w_insn_pend && !r_insn_valid) begin
                r_insn_seen <= bus.insn_toggle;
                if (r_state == S_LOAD) begin
                    r_insn_valid  <= 1'b1;
                    r_insn_bits_0 <= bus.insn_bits_0;
                    r_insn_bits_1 <= bus.insn_bits_1;
                end else begin
                    r_insn_ack <= ~r_insn_ack;
                end
            end

            if (w_in_hs) begin
                r_in_valid <= 1'b0;
                r_in_ack   <= ~r_in_ack;
            end else if (w_in_pend && !r_in_valid) begin
                r_in_seen <= bus.in_toggle;
                if (r_state == S_RUN) begin
                    r_in_valid <= 1'b1;
                    r_in_bits  <= bus.in_bits;
                end else begin
                    r_in_ack <= ~r_in_ack;
                end
            end

            if (w_out_pend) begin
                r_out_seen  <= bus.out_toggle;
                r_out_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_out_valid  <= 1'b1;
                r_out_bits   <= bus.core_io_o_bits;
                r_steps_done <= w_steps_nxt;
            end

            if (w_start_ok) begin
                r_expected     <= CNT_W'(bus.cfg_used_procs) * CNT_W'(bus.cfg_insns_per_proc);
                r_steps        <= bus.cfg_host_steps;
                r_insns_loaded <= '0;
                r_steps_done   <= '0;
                r_out_valid    <= 1'b0;
                r_out_bits     <= '0;
                r_state        <= S_LOAD;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (r_expected == '0) begin
                            r_state <= S_RUN;
                        end else if (w_insn_hs) begin
                            r_insns_loaded <= w_loaded_nxt;
                            if (w_loaded_nxt == r_expected)
                                r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (r_steps_done == r_steps || (w_out_hs && w_steps_nxt == r_steps))
                            r_state <= S_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.insn_ack          = r_insn_ack;
    assign bus.in_ack            = r_in_ack;
    assign bus.out_valid         = r_out_valid;
    assign bus.out_bits          = r_out_bits;
    assign bus.state             = r_state;
    assign bus.insns_loaded      = r_insns_loaded;
    assign bus.steps_done        = r_steps_done;
    assign bus.err               = r_err;
    assign bus.core_insns_valid  = r_insn_valid;
    assign bus.core_insns_bits_0 = r_insn_bits_0;
    assign bus.core_insns_bits_1 = r_insn_bits_1;
    assign bus.core_io_i_valid   = r_in_valid;
    assign bus.core_io_i_bits    = r_in_bits;
    assign bus.core_io_o_ready   = w_out_ready;
endmodule

// File: tb/tb_emu_host_sequencer.sv
// Scoreboard bench for emu_host_sequencer: host toggles and a simple core model
// drive the DUT; expected core beats and io_o words are queued and popped on arrival.
module tb_emu_host_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    emu_host_sequencer_if bus ();

    emu_host_sequencer dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_insn_beats = 0;
    int n_in_beats = 0;
    logic [31:0] q_insn[$];
    logic [31:0] q_in[$];
    logic [31:0] q_out[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core-side monitor; valid/ready only change just after posedge, so negedge sees the handshake.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.core_insns_valid && bus.core_insns_ready) begin
                n_insn_beats++;
                if (q_insn.size() == 0) chk("insn_unexpected_beat", 32'(q_insn.size()), 32'd1);
                else chk("insn_beat_bits", {bus.core_insns_bits_1, bus.core_insns_bits_0}, q_insn.pop_front());
            end
            if (bus.core_io_i_valid && bus.core_io_i_ready) begin
                n_in_beats++;
                if (q_in.size() == 0) chk("in_unexpected_beat", 32'(q_in.size()), 32'd1);
                else chk("in_beat_bits", {16'h0, bus.core_io_i_bits}, q_in.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_run(input logic [2:0] p, input logic [7:0] d, input logic [15:0] s);
        bus.cfg_used_procs     = p;
        bus.cfg_insns_per_proc = d;
        bus.cfg_host_steps     = s;
        bus.start_toggle       = ~bus.start_toggle;
        cyc(1);
    endtask

    task automatic host_insn(input logic [15:0] b0, input logic [15:0] b1, input bit fwd, output bit acked);
        logic a0;
        a0 = bus.insn_ack;
        bus.insn_bits_0 = b0;
        bus.insn_bits_1 = b1;
        bus.insn_toggle = ~bus.insn_toggle;
        if (fwd) q_insn.push_back({b1, b0});
        acked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.insn_ack != a0) begin
                acked = 1'b1;
                break;
            end
        end
        chk("insn_ack_seen", 32'(acked), 32'd1);
    endtask

    task automatic host_in(input logic [15:0] b, input bit fwd);
        logic a0;
        bit ok;
        a0 = bus.in_ack;
        bus.in_bits = b;
        bus.in_toggle = ~bus.in_toggle;
        if (fwd) q_in.push_back({16'h0, b});
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.in_ack != a0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("in_ack_seen", 32'(ok), 32'd1);
    endtask

    task automatic core_send_o(input logic [15:0] w);
        bit ok;
        q_out.push_back({16'h0, w});
        bus.core_io_o_bits  = w;
        bus.core_io_o_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        bus.core_io_o_valid = 1'b0;
        chk("io_o_captured", 32'(ok), 32'd1);
        chk("io_o_ready_when_full", 32'(bus.core_io_o_ready), 32'd0);
    endtask

    task automatic host_read_out();
        chk("out_valid_before_read", 32'(bus.out_valid), 32'd1);
        if (q_out.size() == 0) chk("out_unexpected_word", 32'(q_out.size()), 32'd1);
        else chk("out_bits", {16'h0, bus.out_bits}, q_out.pop_front());
        bus.out_toggle = ~bus.out_toggle;
        cyc(2);
        chk("out_released", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_loaded"}, 32'(bus.insns_loaded), 32'd0);
        chk({tag, "_steps"}, 32'(bus.steps_done), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_acks"}, {30'd0, bus.insn_ack, bus.in_ack}, 32'd0);
        chk({tag, "_out"}, {15'd0, bus.out_valid, bus.out_bits}, 32'd0);
        chk({tag, "_core_v"}, {29'd0, bus.core_insns_valid, bus.core_io_i_valid, bus.core_io_o_ready}, 32'd0);
    endtask

    initial begin
        int base;
        int n_acks;
        bit acked;
        logic a0;
        bus.cfg_host_steps = '0;  bus.cfg_used_procs = '0;  bus.cfg_insns_per_proc = '0;
        bus.start_toggle = 0;  bus.insn_toggle = 0;  bus.in_toggle = 0;  bus.out_toggle = 0;
        bus.insn_bits_0 = '0;  bus.insn_bits_1 = '0;  bus.in_bits = '0;
        bus.core_insns_ready = 0;  bus.core_io_i_ready = 0;
        bus.core_io_o_valid = 0;  bus.core_io_o_bits = '0;
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check_all_zero("reset");

        // Load 2x3 instructions with the core always ready.
        bus.core_insns_ready = 1'b1;
        start_run(3'd2, 8'd3, 16'd4);
        chk("t1_state_load", 32'(bus.state), 32'd1);
        base = n_insn_beats;
        n_acks = 0;
        for (int i = 0; i < 6; i++) begin
            host_insn(16'(16'h0100 + i), 16'(16'hC000 + 3 * i), 1'b1, acked);
            if (acked) n_acks++;
        end
        chk("t1_ack_count", 32'(n_acks), 32'd6);
        chk("t1_core_beats", 32'(n_insn_beats - base), 32'd6);
        chk("t1_loaded", 32'(bus.insns_loaded), 32'd6);
        chk("t1_state_run", 32'(bus.state), 32'd2);

        // Four io_i beats, then four io_o words 0x0011..0x0014 released by the host.
        bus.core_io_i_ready = 1'b1;
        base = n_in_beats;
        for (int i = 0; i < 4; i++) host_in(16'(16'h7700 + i), 1'b1);
        chk("t2_in_beats", 32'(n_in_beats - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            core_send_o(16'(16'h0011 + i));
            host_read_out();
        end
        chk("t2_steps", 32'(bus.steps_done), 32'd4);
        chk("t2_last_out", 32'(bus.out_bits), 32'h0014);
        chk("t2_state_done", 32'(bus.state), 32'd3);
        chk("t2_err", 32'(bus.err), 32'd0);
        chk("t2_o_ready_done", 32'(bus.core_io_o_ready), 32'd0);

        // Stall the insn channel, flip again while busy.
        bus.core_insns_ready = 1'b0;
        start_run(3'd1, 8'd2, 16'd0);
        chk("t3_state_load", 32'(bus.state), 32'd1);
        base = n_insn_beats;
        bus.insn_bits_0 = 16'hA5A5;
        bus.insn_bits_1 = 16'h5A5A;
        bus.insn_toggle = ~bus.insn_toggle;
        q_insn.push_back(32'h5A5A_A5A5);
        cyc(1);
        chk("t3_valid_latency", 32'(bus.core_insns_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.insn_bits_0 = 16'h1234;
                bus.insn_bits_1 = 16'h4321;
                bus.insn_toggle = ~bus.insn_toggle;
                q_insn.push_back(32'h4321_1234);
            end
            cyc(1);
            chk("t3_valid_stable", 32'(bus.core_insns_valid), 32'd1);
            chk("t3_bits_stable", {bus.core_insns_bits_1, bus.core_insns_bits_0}, 32'h5A5A_A5A5);
        end
        chk("t4_err_busy_flip", 32'(bus.err), 32'd1);
        a0 = bus.insn_ack;
        bus.core_insns_ready = 1'b1;
        cyc(1);
        chk("t3_ack_one_cycle", 32'(bus.insn_ack != a0), 32'd1);
        chk("t3_valid_dropped", 32'(bus.core_insns_valid), 32'd0);
        a0 = bus.insn_ack;
        acked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.insn_ack != a0) begin
                acked = 1'b1;
                break;
            end
        end
        chk("t4_second_ack", 32'(acked), 32'd1);
        cyc(2);
        chk("t4_core_beats", 32'(n_insn_beats - base), 32'd2);
        chk("t4_loaded", 32'(bus.insns_loaded), 32'd2);
        chk("t4_state_done", 32'(bus.state), 32'd3);

        // Empty run: IDLE/DONE -> LOAD -> RUN -> DONE with no beats.
        base = n_insn_beats;
        start_run(3'd0, 8'd5, 16'd0);
        chk("t5_state_load", 32'(bus.state), 32'd1);
        chk("t5_err_cleared", 32'(bus.err), 32'd0);
        cyc(1);
        chk("t5_state_run", 32'(bus.state), 32'd2);
        cyc(1);
        chk("t5_state_done", 32'(bus.state), 32'd3);
        chk("t5_no_beats", 32'(n_insn_beats - base), 32'd0);
        base = n_in_beats;
        host_in(16'hDEAD, 1'b0);
        chk("t5_stray_err", 32'(bus.err), 32'd1);
        chk("t5_stray_no_beat", 32'(n_in_beats - base), 32'd0);

        // Reset in the middle of LOAD, then a clean one-step run.
        start_run(3'd2, 8'd3, 16'd1);
        for (int i = 0; i < 3; i++) host_insn(16'(16'h0A00 + i), 16'h00FF, 1'b1, acked);
        chk("t6_loaded_before_reset", 32'(bus.insns_loaded), 32'd3);
        bus.start_toggle = 0;  bus.insn_toggle = 0;  bus.in_toggle = 0;  bus.out_toggle = 0;
        reset = 1'b1;
        cyc(2);
        check_all_zero("t6_mid_reset");
        reset = 1'b0;
        cyc(1);
        start_run(3'd1, 8'd1, 16'd1);
        host_insn(16'h0BAD, 16'hF00D, 1'b1, acked);
        chk("t6_state_run", 32'(bus.state), 32'd2);
        host_in(16'h0042, 1'b1);
        core_send_o(16'hBEEF);
        chk("t6_state_done", 32'(bus.state), 32'd3);
        chk("t6_steps", 32'(bus.steps_done), 32'd1);
        host_read_out();
        chk("t6_loaded", 32'(bus.insns_loaded), 32'd1);
        chk("t6_err", 32'(bus.err), 32'd0);

        cyc(2);
        chk("queues_empty", 32'(q_insn.size() + q_in.size() + q_out.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/emu_host_sequencer.md
Name: emu_host_sequencer

Overview:
Host-clock-domain controller between the Opal Kelly wire endpoints and the emulator core's io_host port. Wire-ins are level-only, so the host issues each beat by flipping a toggle bit. This block converts those toggles into single valid/ready beats on the core's insns and io_i channels, and buffers one io_o word for host readback. It also sequences the run as a state machine (IDLE, LOAD, RUN, DONE), counting instructions loaded and target steps completed.

Parameters:
DATA_W, 16, width of insns_bits_0/1, io_i and io_o words
STEP_W, 16, width of host_steps and the step counter
PROC_W, 3, width of used_procs
DEPTH_W, 8, width of insns_per_proc

Ports:
clock  in  1  host clock (okClk); the only clock
reset  in  1  asynchronous, active-high
cfg_host_steps  in  STEP_W  target steps per run
cfg_used_procs  in  PROC_W  active processors
cfg_insns_per_proc  in  DEPTH_W  instructions per processor
start_toggle  in  1  flip to begin a run
insn_toggle  in  1  flip to issue one instruction beat
insn_bits_0, insn_bits_1  in  DATA_W each  instruction payload
in_toggle  in  1  flip to issue one io_i beat
in_bits  in  DATA_W  io_i payload
out_toggle  in  1  flip to release the io_o buffer
insn_ack, in_ack  out  1 each  flips on completion of the matching beat
out_valid  out  1  io_o buffer holds a word
out_bits  out  DATA_W  buffered io_o word
state  out  2  0=IDLE, 1=LOAD, 2=RUN, 3=DONE
insns_loaded  out  PROC_W+DEPTH_W  instruction beats completed this run
steps_done  out  STEP_W  io_o words captured this run
err  out  1  sticky protocol error
core_insns_valid  out  1  to core
core_insns_ready  in  1  from core
core_insns_bits_0, core_insns_bits_1  out  DATA_W each  to core
core_io_i_valid  out  1  to core
core_io_i_ready  in  1  from core
core_io_i_bits  out  DATA_W  to core
core_io_o_valid  in  1  from core
core_io_o_ready  out  1  to core
core_io_o_bits  in  DATA_W  from core

Behaviour:
- Reset: every output and internal register goes to 0. This includes all toggle-seen registers, ack registers, out buffer, counters and err; state=IDLE.
- Reset mid-run abandons any in-flight beat. The host must zero all of its toggles while reset is asserted.
- Toggle detection: each input toggle has a registered seen bit. A request is pending when toggle != seen.
- On detection: seen takes the new toggle value and the payload is captured into a holding register. The core-side valid rises on the next cycle.
- Valid and bits stay stable until ready. At the handshake cycle, valid drops and ack flips on the following edge.
- Minimum latency: toggle edge to core valid = 1 cycle; handshake to ack = 1 cycle.
- If a toggle flips again while its channel is busy, set err. The new flip is detected only after the current beat completes.
- start_toggle, accepted in IDLE or DONE:
  - latch expected = cfg_used_procs * cfg_insns_per_proc (full width PROC_W+DEPTH_W, no truncation) and latch cfg_host_steps;
  - clear insns_loaded, steps_done, out buffer and err; enter LOAD.
- start_toggle in LOAD or RUN: set err; no other effect.
- LOAD:
  - insn beats are forwarded and insns_loaded increments per handshake;
  - move to RUN on the cycle insns_loaded reaches expected; if expected==0, go straight to RUN the cycle after start.
- RUN:
  - in beats are forwarded to io_i;
  - core_io_o_ready = !out_valid;
  - on io_o handshake: capture out_bits, set out_valid, increment steps_done;
  - move to DONE when steps_done reaches the latched steps; if steps==0, enter DONE immediately from RUN.
- Off-state toggles:
  - insn_toggle outside LOAD: consumed with no core beat, ack flips, err set;
  - in_toggle outside RUN: consumed with no core beat, ack flips, err set.
- out_toggle flip clears out_valid; out_bits holds its last value. A flip while out_valid=0 sets err.
- Release and capture in the same cycle cannot occur, because io_o ready is low while the buffer is full.
- DONE: core_io_o_ready=0. The buffered word stays readable until the host releases it.
- Counters do not wrap. steps_done saturates at the latched target by construction.

Test Plan:
- Reset, then used_procs=2, insns_per_proc=3, start flip, 6 insn flips with core ready=1 -> 6 core beats, insn_ack toggles 6 times, insns_loaded=6, state=RUN.
- In RUN with host_steps=4: 4 in flips; core returns io_o 0x0011..0x0014, host releases each -> steps_done=4, last out_bits=0x0014, state=DONE, err=0.
- core_insns_ready held low for 5 cycles -> valid and bits stable throughout; ack flips exactly 1 cycle after the handshake.
- Second insn_toggle flip while the first beat is stalled -> err=1; exactly 2 core beats once ready is asserted.
- used_procs=0 with host_steps=0 -> IDLE to LOAD to RUN to DONE, zero core beats; a stray in flip in DONE -> in_ack flips, err=1.
- reset asserted mid-LOAD after 3 beats -> all outputs 0, state=IDLE; a fresh start reloads cleanly.
